// File: rtl/mac_ts_reader.sv
// mac_ts_reader: captures rx timestamps into a FIFO that host software drains through a req/ack register port.
module mac_ts_reader #(
  parameter int DEPTH_BITS = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           ts_in,
  input  logic                  ts_valid,
  input  logic                  reg_req,
  input  logic                  reg_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_ack,
  output logic                  ts_pending
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW = DEPTH_BITS + 1;
  localparam logic [ADDR_WIDTH-1:0] TS_LOW = ADDR_WIDTH'(0), TS_HIGH = ADDR_WIDTH'(1),
    STATUS = ADDR_WIDTH'(2), DROPPED = ADDR_WIDTH'(3), CTRL = ADDR_WIDTH'(4);
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  state_t state, state_nxt;
  logic [63:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [31:0] dropped, rd_word;
  logic [63:0] head;
  logic overflow, enable, empty, full, accept, wr;
  logic op_pop, op_flush, op_clr_ovf, op_clr_drop, op_ctrl, op_en;
  logic in_ack, pop, flush, push, drop, wr_en;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign head = empty ? '0 : mem[rd_ptr];
  assign accept = state == IDLE && reg_req;
  assign wr = !reg_rd_wr_L;
  assign in_ack = state == ACK;
  assign reg_ack = in_ack;
  assign pop = in_ack && op_pop;
  assign flush = in_ack && op_flush;
  assign push = ts_valid && enable && !flush;
  assign drop = push && full && !pop;
  assign wr_en = push && !drop;
  assign count_nxt = flush ? '0 : count + CW'(wr_en) - CW'(pop);
  always_comb begin
    state_nxt = state == IDLE ? (reg_req ? ACK : IDLE) : state == ACK ? WAIT : (reg_req ? WAIT : IDLE);
    rd_word = reg_addr == TS_LOW  ? head[31:0] :
              reg_addr == TS_HIGH ? head[63:32] :
              reg_addr == STATUS  ? {13'd0, overflow, full, empty, 16'(count)} :
              reg_addr == DROPPED ? dropped :
              reg_addr == CTRL    ? {31'd0, enable} : '0;
  end
  // Side effects are decided from the request as sampled in IDLE and applied in the ACK cycle.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      dropped <= '0;
      enable <= 1'b1;
      reg_rd_data <= '0;
      ts_pending <= 1'b0;
      {op_pop, op_flush, op_clr_ovf, op_clr_drop, op_ctrl, op_en} <= '0;
    end else begin
      state <= state_nxt;
      reg_rd_data <= accept && reg_rd_wr_L ? DATA_WIDTH'(rd_word) : '0;
      if (accept) begin
        op_pop <= !wr && reg_addr == TS_HIGH && !empty;
        op_flush <= wr && reg_addr == CTRL && reg_wr_data[1];
        op_clr_ovf <= wr && reg_addr == STATUS && reg_wr_data[18];
        op_clr_drop <= wr && reg_addr == DROPPED;
        op_ctrl <= wr && reg_addr == CTRL;
        op_en <= reg_wr_data[0];
      end
      wr_ptr <= flush ? '0 : wr_ptr + DEPTH_BITS'(wr_en);
      rd_ptr <= flush ? '0 : rd_ptr + DEPTH_BITS'(pop);
      count <= count_nxt;
      ts_pending <= count_nxt != '0;
      overflow <= (overflow && !(in_ack && op_clr_ovf)) || drop;
      dropped <= in_ack && op_clr_drop ? 32'(drop) : dropped + 32'(drop && dropped != '1);
      if (in_ack && op_ctrl) enable <= op_en;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= ts_in;
endmodule
